// File: rtl/memory_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_pkg: access-size and FSM state types, load extension helper  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package memory_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } size_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   // Right-align the addressed lane(s) of a captured word, then extend.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input size_t       size,
                                               input logic        is_unsigned);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = word >> {lane, 3'b000};
      case (size)
         SIZE_BYTE: result = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: result = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
         default:   result = shifted;
      endcase
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_data_memory_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_data_memory_if: request/response bus of the byte data memory   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface byte_data_memory_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int WORD_WIDTH    = 32
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [1:0]               req_size;
   logic                     req_unsigned;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [WORD_WIDTH-1:0]    write_data;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [WORD_WIDTH-1:0]    read_data;
   logic                     fault;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, address, write_data, resp_ready,
      input  req_ready, resp_valid, read_data, fault
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, address, write_data, resp_ready,
      output req_ready, resp_valid, read_data, fault
   );
endinterface
`default_nettype wire

// File: rtl/byte_lane_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_lane_ram: word array with per-byte-lane write enables          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module byte_lane_ram #(
   parameter int NUM_WORDS  = 256,
   parameter int WORD_WIDTH = 32,
   parameter int IDX_W      = $clog2(NUM_WORDS),
   parameter int LANES      = WORD_WIDTH / 8
) (
   input  logic                  clock,
   input  logic [IDX_W-1:0]      index,
   input  logic [LANES-1:0]      write_en,
   input  logic [WORD_WIDTH-1:0] write_data,
   input  logic                  read_en,
   output logic [WORD_WIDTH-1:0] read_data
);

   // Contents are deliberately never reset.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] mem [NUM_WORDS];
      logic [7:0] r_q;

      always_ff @(posedge clock) begin
         if (write_en[l])
            mem[index] <= write_data[8*l +: 8];
         if (read_en)
            r_q <= mem[index];
      end

      assign read_data[8*l +: 8] = r_q;
   end

endmodule
`default_nettype wire

// File: rtl/byte_data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_data_memory: byte-addressable load/store memory, 1 outstanding |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module byte_data_memory
   import memory_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int WORD_WIDTH    = 32,
   parameter int NUM_WORDS     = 256
) (
   input  logic               clock,
   input  logic               reset_n,
   byte_data_memory_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_WORDS);

   state_t            r_state;
   state_t            w_state_next;
   logic              w_resp_valid;
   logic              w_accept;
   logic [1:0]        w_lane;
   logic [IDX_W-1:0]  w_index;
   size_t             w_size;
   logic              w_fault;
   logic [3:0]        w_we_lanes;
   logic [3:0]        w_we;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ram_q;

   logic              r_fault;
   logic              r_load;
   logic [1:0]        r_lane;
   size_t             r_size;
   logic              r_unsigned;

   assign w_resp_valid  = (r_state == ST_RESP);
   assign bus.resp_valid = w_resp_valid;
   assign bus.req_ready  = !w_resp_valid || bus.resp_ready;
   // Gating with reset_n keeps requests presented during reset from writing.
   assign w_accept = bus.req_valid && bus.req_ready && reset_n;

   assign w_lane  = bus.address[1:0];
   assign w_index = bus.address[IDX_W+1:2];
   assign w_size  = size_t'(bus.req_size);

   always_comb begin
      w_fault = 1'b0;
      if ((bus.address >> (IDX_W + 2)) != '0)
         w_fault = 1'b1;
      case (w_size)
         SIZE_HALF:    if (w_lane[0])       w_fault = 1'b1;
         SIZE_WORD:    if (w_lane != 2'b00) w_fault = 1'b1;
         SIZE_ILLEGAL: w_fault = 1'b1;
         default:      ;
      endcase
   end

   always_comb begin
      w_we_lanes = 4'b0000;
      w_wdata    = bus.write_data;
      case (w_size)
         SIZE_BYTE: begin
            w_we_lanes = 4'b0001 << w_lane;
            w_wdata    = {4{bus.write_data[7:0]}};
         end
         SIZE_HALF: begin
            w_we_lanes = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{bus.write_data[15:0]}};
         end
         SIZE_WORD: w_we_lanes = 4'b1111;
         default:   w_we_lanes = 4'b0000;
      endcase
   end

   assign w_we = (w_accept && bus.req_write && !w_fault) ? w_we_lanes : 4'b0000;

   byte_lane_ram #(
      .NUM_WORDS  (NUM_WORDS),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_ram (
      .clock      (clock),
      .index      (w_index),
      .write_en   (w_we),
      .write_data (w_wdata),
      .read_en    (w_accept && !bus.req_write && !w_fault),
      .read_data  (w_ram_q)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)                       w_state_next = ST_RESP;
         ST_RESP: if (bus.resp_ready && !w_accept)    w_state_next = ST_IDLE;
         default:                                     w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_fault    <= 1'b0;
         r_load     <= 1'b0;
         r_lane     <= 2'b00;
         r_size     <= SIZE_BYTE;
         r_unsigned <= 1'b0;
      end else if (w_accept) begin
         r_fault    <= w_fault;
         r_load     <= !bus.req_write && !w_fault;
         r_lane     <= w_lane;
         r_size     <= w_size;
         r_unsigned <= bus.req_unsigned;
      end
   end

   assign bus.read_data = (w_resp_valid && r_load)
                        ? load_extend(w_ram_q, r_lane, r_size, r_unsigned) : '0;
   assign bus.fault     = w_resp_valid && r_fault;

endmodule
`default_nettype wire

// File: tb/tb_byte_data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_byte_data_memory: directed vector table plus handshake sequences |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_byte_data_memory;
   import memory_pkg::*;

   localparam int ADDRESS_WIDTH = 32;
   localparam int WORD_WIDTH    = 32;
   localparam int NUM_WORDS     = 256;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   byte_data_memory_if #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .WORD_WIDTH(WORD_WIDTH)) bus ();

   byte_data_memory #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .WORD_WIDTH    (WORD_WIDTH),
      .NUM_WORDS     (NUM_WORDS)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_fault;
   } vec_t;

   vec_t vq[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.address      = addr;
      bus.write_data   = wdata;
   endtask

   task automatic add(input string name, input logic wr, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_fault);
      vec_t v;
      v.name = name; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
      v.wdata = wdata; v.exp_data = exp_data; v.exp_fault = exp_fault;
      vq.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clock);
      drive(v.wr, v.size, v.uns, v.addr, v.wdata);
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      check({v.name, ".valid"}, {31'h0, bus.resp_valid}, 32'h1);
      check({v.name, ".data"},  bus.read_data, v.exp_data);
      check({v.name, ".fault"}, {31'h0, bus.fault}, {31'h0, v.exp_fault});
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.address      = '0;
      bus.write_data   = '0;
      bus.resp_ready   = 1'b1;
      reset_n          = 1'b0;

      add("st_w_10",      1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
      add("ld_bu_13",     0, 2'b00, 1, 32'h13,  32'h0,        32'h000000DE, 0);
      add("ld_bs_13",     0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
      add("ld_hu_12",     0, 2'b01, 1, 32'h12,  32'h0,        32'h0000DEAD, 0);
      add("ld_hs_10",     0, 2'b01, 0, 32'h10,  32'h0,        32'hFFFFBEEF, 0);
      add("ld_w_10",      0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
      add("st_w_20",      1, 2'b10, 0, 32'h20,  32'h0,        32'h0,        0);
      add("st_b_21",      1, 2'b00, 0, 32'h21,  32'h12345680, 32'h0,        0);
      add("ld_bs_21",     0, 2'b00, 0, 32'h21,  32'h0,        32'hFFFFFF80, 0);
      add("ld_w_20",      0, 2'b10, 0, 32'h20,  32'h0,        32'h00008000, 0);
      add("st_w_04",      1, 2'b10, 0, 32'h04,  32'h11223344, 32'h0,        0);
      add("ld_h_03_mis",  0, 2'b01, 0, 32'h03,  32'h0,        32'h0,        1);
      add("st_w_06_mis",  1, 2'b10, 0, 32'h06,  32'hAAAAAAAA, 32'h0,        1);
      add("ld_w_04",      0, 2'b10, 0, 32'h04,  32'h0,        32'h11223344, 0);
      add("ld_w_oor",     0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1);
      add("ld_size11",    0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1);
      add("st_h_22",      1, 2'b01, 0, 32'h22,  32'h1234CAFE, 32'h0,        0);
      add("ld_w_20b",     0, 2'b10, 0, 32'h20,  32'h0,        32'hCAFE8000, 0);
      add("ld_hu_22",     0, 2'b01, 1, 32'h22,  32'h0,        32'h0000CAFE, 0);
      add("st_b_oor",     1, 2'b00, 0, 32'h410, 32'h55,       32'h0,        1);
      add("ld_w_10b",     0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);

      #12;
      check("rst.valid", {31'h0, bus.resp_valid}, 32'h0);
      check("rst.ready", {31'h0, bus.req_ready},  32'h1);
      check("rst.data",  bus.read_data,           32'h0);
      check("rst.fault", {31'h0, bus.fault},      32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      foreach (vq[i]) run_vec(vq[i]);

      // Stalled response: held for 3 cycles while a second request waits.
      @(negedge clock);
      bus.resp_ready = 1'b0;
      drive(0, 2'b10, 0, 32'h10, 32'h0);
      @(posedge clock);
      #1;
      drive(0, 2'b10, 0, 32'h04, 32'h0);
      check("stall.first", bus.read_data, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check("stall.ready", {31'h0, bus.req_ready},  32'h0);
         check("stall.valid", {31'h0, bus.resp_valid}, 32'h1);
         check("stall.data",  bus.read_data,           32'hDEADBEEF);
         check("stall.fault", {31'h0, bus.fault},      32'h0);
      end
      @(negedge clock);
      bus.resp_ready = 1'b1;
      #1;
      check("stall.release_ready", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      check("stall.second_valid", {31'h0, bus.resp_valid}, 32'h1);
      check("stall.second_data",  bus.read_data,           32'h11223344);
      @(posedge clock);
      #1;
      check("stall.drain", {31'h0, bus.resp_valid}, 32'h0);

      // Back-to-back, including a load right after a store to the same word.
      @(negedge clock);
      drive(1, 2'b10, 0, 32'h30, 32'h01020304);
      @(posedge clock);
      #1;
      drive(0, 2'b00, 1, 32'h31, 32'h0);
      check("b2b.st_valid", {31'h0, bus.resp_valid}, 32'h1);
      check("b2b.st_data",  bus.read_data,           32'h0);
      check("b2b.st_fault", {31'h0, bus.fault},      32'h0);
      @(posedge clock);
      #1;
      drive(0, 2'b01, 0, 32'h32, 32'h0);
      check("b2b.ld_byte", bus.read_data, 32'h00000003);
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      check("b2b.ld_half", bus.read_data, 32'h00000102);
      check("b2b.valid",   {31'h0, bus.resp_valid}, 32'h1);
      @(posedge clock);
      #1;
      check("b2b.idle", {31'h0, bus.resp_valid}, 32'h0);

      // Reset with a response pending and a store held through reset.
      @(negedge clock);
      bus.resp_ready = 1'b0;
      drive(0, 2'b10, 0, 32'h10, 32'h0);
      @(posedge clock);
      #1;
      drive(1, 2'b10, 0, 32'h10, 32'hFFFFFFFF);
      check("mrst.pending", {31'h0, bus.resp_valid}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mrst.valid", {31'h0, bus.resp_valid}, 32'h0);
      check("mrst.ready", {31'h0, bus.req_ready},  32'h1);
      check("mrst.data",  bus.read_data,           32'h0);
      check("mrst.fault", {31'h0, bus.fault},      32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      reset_n        = 1'b1;
      begin
         vec_t v;
         v.name = "post_rst_10"; v.wr = 0; v.size = 2'b10; v.uns = 0; v.addr = 32'h10;
         v.wdata = 32'h0; v.exp_data = 32'hDEADBEEF; v.exp_fault = 0;
         run_vec(v);
         v.name = "post_rst_30"; v.addr = 32'h30; v.exp_data = 32'h01020304;
         run_vec(v);
      end

      @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, data width; fixed at 32 in this generation.
REQ-003 SHALL have parameter NUM_WORDS, default 256, array depth in words; power of two, at least 4.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request can be accepted this cycle.
REQ-008 SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-009 SHALL have port req_size, input, 2, 00=byte, 01=half, 10=word, 11=illegal.
REQ-010 SHALL have port req_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-011 SHALL have port address, input, ADDRESS_WIDTH, byte address.
REQ-012 SHALL have port write_data, input, WORD_WIDTH, store data, right-aligned.
REQ-013 SHALL have port resp_valid, output, 1, response present.
REQ-014 SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-015 SHALL have port read_data, output, WORD_WIDTH, extended load result; 0 for stores and faults.
REQ-016 SHALL have port fault, output, 1, request was misaligned, out of range or illegal size; qualified by resp_valid.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL drive req_ready = !resp_valid || resp_ready, combinationally, giving one outstanding response and full throughput.
REQ-019 SHALL assert resp_valid one cycle after acceptance and hold it until resp_valid && resp_ready.
REQ-020 SHALL hold read_data and fault stable while resp_valid && !resp_ready.
REQ-021 SHALL compute word index = address[log2(NUM_WORDS)+1:2] and byte lane = address[1:0].
REQ-022 SHALL fault when half access has address[0]=1, word access has address[1:0]!=0, req_size=11, or address[ADDRESS_WIDTH-1:log2(NUM_WORDS)+2] is nonzero.
REQ-023 SHALL, for a faulting request, leave memory unchanged and return read_data=0, fault=1.
REQ-024 SHALL write a store at the acceptance edge, updating only the addressed lanes: byte = 1 lane, half = lanes {1:0} or {3:2}, word = all 4.
REQ-025 SHALL take the store byte from write_data[7:0] and the store half from write_data[15:0], replicated onto the target lanes.
REQ-026 SHALL capture load data at the acceptance edge, then shift it right by 8*lane and sign- or zero-extend it from 8 or 16 bits per req_size/req_unsigned.
REQ-027 SHALL return a store response with read_data=0, fault=0.
REQ-028 SHALL give a load accepted the cycle after a store to the same word the post-store data (no stale read).
REQ-029 SHALL implement a two-state FSM: IDLE (resp_valid=0) and RESP (resp_valid=1).
REQ-030 SHALL transition IDLE->RESP on accept.
REQ-031 SHALL transition RESP->IDLE on resp_ready with no new accept.
REQ-032 SHALL stay in RESP and reload the response on resp_ready together with a new accept.

Reset
REQ-033 SHALL, while reset_n=0, force state=IDLE, resp_valid=0, read_data=0, fault=0, and thus req_ready=1, asynchronously.
REQ-034 SHALL, on reset mid-transaction, drop the pending response and leave memory array contents unreset and unchanged.
REQ-035 SHALL ignore requests while reset_n=0 and write nothing.

Structure
REQ-036 SHALL place the access-size enum (BYTE, HALF, WORD, ILLEGAL) and state enum in shared package memory_pkg.
REQ-037 SHALL place the load-extension function in memory_pkg.
REQ-038 SHALL isolate the storage array with per-lane write enables in one sub-module, byte_lane_ram.

Verification
REQ-039 SHALL cover: word store 0xDEADBEEF @0x10, then unsigned byte load @0x13 -> resp_valid next cycle, read_data=0x000000DE, fault=0.
REQ-040 SHALL cover: byte store 0x80 @0x21 over word 0 at 0x20, then signed byte load @0x21 -> 0xFFFFFF80; word load @0x20 -> 0x00008000.
REQ-041 SHALL cover: half load @0x03 -> fault=1, read_data=0; word store @0x06 -> fault=1 and word 1 unchanged.
REQ-042 SHALL cover: address 4*NUM_WORDS -> fault=1; req_size=11 -> fault=1.
REQ-043 SHALL cover: resp_ready=0 for 3 cycles with a response pending -> req_ready=0 and the response held; back-to-back requests with resp_ready=1 -> one response per cycle.
REQ-044 SHALL cover: reset_n pulsed low while resp_valid=1 -> resp_valid=0 immediately, and previously stored data is still readable after reset.
